// File: rtl/uart_tx_sched_pkg.sv
// Shared types and default parameters for the UART transmit scheduler.
// States exist in every build; HDR is reachable only with UART_TX_SCHED_HEADER_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    START = 3'd3,
    SHIFT = 3'd4
  } sched_state_t;

  localparam int          N_REQ_DEF       = 4;
  localparam int          GAP_TIMEOUT_DEF = 1024;
  localparam logic [7:0]  ID_BASE_DEF     = 8'hA0;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte streams plus the UART start/ready port and scheduler status.
// slave = scheduler view, master = requesters/UART/observer view.
interface uart_tx_sched_if #(
  parameter int N_REQ = 4
) ();

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               start_tx;
  logic               tx_ready;
  logic [IDX_W-1:0]   grant_id;
  logic               busy;
  logic               gap_abort;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, start_tx, grant_id, busy, gap_abort
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, start_tx, grant_id, busy, gap_abort
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i+1 (mod N_REQ).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx       = '0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    // Walk from lowest priority to highest so the nearest candidate wins last.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((32'(ptr_i) + 32'(k)) % 32'(N_REQ));
      if (req_i[idx]) begin
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one UART transmitter among N_REQ streams.
// Define UART_TX_SCHED_HEADER_EN to prefix every packet with byte ID_BASE+grant_id.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         N_REQ       = N_REQ_DEF,
  parameter int         GAP_TIMEOUT = GAP_TIMEOUT_DEF
`ifdef UART_TX_SCHED_HEADER_EN
  ,
  parameter logic [7:0] ID_BASE     = ID_BASE_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.slave  bus
);

  localparam int               IDX_W   = $clog2(N_REQ);
  localparam int               CNT_W   = $clog2(GAP_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_t     state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             busy_q;
  logic             start_q;
  logic [7:0]       tx_data_q;
  logic             last_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_d;
  logic             abort_q;
`ifdef UART_TX_SCHED_HEADER_EN
  logic             hdr_q;
`endif

  logic [N_REQ-1:0] arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic             cur_valid;
  logic [7:0]       cur_data;
  logic             cur_last;
  logic [N_REQ-1:0] ready_oh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  assign cur_valid = bus.req_valid[grant_q];
  assign cur_data  = bus.req_data[{grant_q, 3'b000} +: 8];
  assign cur_last  = bus.req_last[grant_q];
  assign gap_d     = sat_inc(gap_q);

  // Only the owner can be handed a byte, and only while its data slot is open.
  always_comb begin
    ready_oh = '0;
`ifdef UART_TX_SCHED_HEADER_EN
    if (state_q == FETCH && cur_valid && !hdr_q) ready_oh[grant_q] = 1'b1;
`else
    if (state_q == FETCH && cur_valid) ready_oh[grant_q] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IDX_W'(N_REQ - 1);
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      tx_data_q <= 8'h00;
      last_q    <= 1'b0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
`ifdef UART_TX_SCHED_HEADER_EN
      hdr_q     <= 1'b0;
`endif
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gap_q <= '0;
          // tx_ready gate also keeps us quiet while a frame from before a reset drains.
          if (bus.tx_ready && (|arb_oh)) begin
            grant_q <= arb_idx;
            busy_q  <= 1'b1;
`ifdef UART_TX_SCHED_HEADER_EN
            state_q <= HDR;
`else
            state_q <= FETCH;
`endif
          end
        end
`ifdef UART_TX_SCHED_HEADER_EN
        HDR: begin
          tx_data_q <= ID_BASE + 8'(grant_q);
          hdr_q     <= 1'b1;
          state_q   <= START;
        end
`endif
        FETCH: begin
          if (cur_valid) begin
            tx_data_q <= cur_data;
            last_q    <= cur_last;
            gap_q     <= '0;
            state_q   <= START;
          end else if (gap_q == GAP_LIM) begin
            abort_q  <= 1'b1;
            rr_ptr_q <= grant_q;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            gap_q <= gap_d;
          end
        end
        START: begin
          // Hold the request until the UART, clocked on baud edges, shows it saw it.
          if (start_q && !bus.tx_ready) begin
            start_q <= 1'b0;
            state_q <= SHIFT;
          end else begin
            start_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.tx_ready) begin
`ifdef UART_TX_SCHED_HEADER_EN
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= FETCH;
            end else
`endif
            if (last_q) begin
              rr_ptr_q <= grant_q;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_oh;
  assign bus.tx_data   = tx_data_q;
  assign bus.start_tx  = start_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;
  assign bus.gap_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester byte queues, a UART model that
// drops tx_ready 3 clk after start_tx and holds it low for a 6-clk frame.
module tb_uart_tx_sched;

  localparam int N     = 4;
  localparam int GAP   = 16;
  localparam int P     = 10;
  localparam int FRAME = 6;
`ifdef UART_TX_SCHED_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_sched_if #(.N_REQ(N)) bus ();

  uart_tx_sched #(.N_REQ(N), .GAP_TIMEOUT(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #(P/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  // UART model
  logic       uart_rdy = 1'b1;
  int         dly = 0, frm = 0, starts = 0, frames = 0;
  time        rise_t = 0;
  logic [7:0] sent_q[$];

  always @(posedge clk) begin
    if (frm > 0) begin
      frm <= frm - 1;
      if (frm == 1) begin
        uart_rdy <= 1'b1;
        frames   <= frames + 1;
        rise_t   <= $time;
      end
    end else if (bus.start_tx && uart_rdy) begin
      if (dly == 2) begin
        uart_rdy <= 1'b0;
        frm      <= FRAME;
        dly      <= 0;
        starts   <= starts + 1;
        sent_q.push_back(bus.tx_data);
      end else begin
        dly <= dly + 1;
      end
    end else begin
      dly <= 0;
    end
  end

  // Requester sources: each presents the head of its queue, pops on req_ready
  logic [8:0]       srcq[N][$];
  logic [N-1:0]     rv = '0;
  logic [N-1:0]     rl = '0;
  logic [8*N-1:0]   rd = '0;
  int               pop_q[$];
  int               ready_cnt[N];
  logic             multi_ready = 1'b0;

  assign bus.req_valid = rv;
  assign bus.req_data  = rd;
  assign bus.req_last  = rl;
  assign bus.tx_ready  = uart_rdy;

  always @(posedge clk) begin
    if ($countones(bus.req_ready) > 1) multi_ready <= 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) begin
        void'(srcq[i].pop_front());
        pop_q.push_back(i);
        ready_cnt[i]++;
      end
      rv[i] <= (srcq[i].size() != 0);
      if (srcq[i].size() != 0) begin
        rd[8*i +: 8] <= srcq[i][0][7:0];
        rl[i]        <= srcq[i][0][8];
      end
    end
  end

  logic [7:0] exp_q[$];
  int         exp_pop[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    srcq[r].push_back({l, b});
  endtask

  task automatic exp_hdr(input int r);
    if (HDR_ON) exp_q.push_back(8'hA0 + 8'(r));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!bus.busy && all_empty() && rv == '0 && uart_rdy && frm == 0 && !bus.start_tx)
               && n < budget);
    chk({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_byte_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
    sent_q.delete();
    exp_q.delete();
  endtask

  task automatic check_pops(input string tag);
    chk({tag, "_pop_count"}, 32'(pop_q.size()), 32'(exp_pop.size()));
    for (int i = 0; i < exp_pop.size() && i < pop_q.size(); i++)
      chk($sformatf("%s_owner%0d", tag, i), 32'(pop_q[i]), 32'(exp_pop[i]));
    pop_q.delete();
    exp_pop.delete();
  endtask

  initial begin
    #(100000 * P);
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, s0, f0, r0, nfr;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_tx",  32'(bus.start_tx),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_gap_abort", 32'(bus.gap_abort), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_tx_data",   32'(bus.tx_data),   32'h00);
    chk("rst_grant_id",  32'(bus.grant_id),  32'd0);

    // Single packet from requester 0
    s0 = starts; f0 = frames; r0 = ready_cnt[0];
    nfr = HDR_ON ? 3 : 2;
    exp_hdr(0); exp_q.push_back(8'h55); exp_q.push_back(8'h3C);
    exp_pop = '{0, 0};
    push(0, 8'h55, 1'b0);
    push(0, 8'h3C, 1'b1);
    n = 0;
    while (!bus.busy && n < 100) begin @(negedge clk); n++; end
    chk("t1_busy_rise", 32'(n < 100), 32'd1);
    n = 0;
    while (bus.busy && n < 300) begin @(negedge clk); n++; end
    chk("t1_busy_fall", 32'(n < 300), 32'd1);
    chk("t1_frames_at_busy_fall", 32'(frames - f0), 32'(nfr));
    chk("t1_tx_ready_at_busy_fall", 32'(uart_rdy), 32'd1);
    wait_idle(200, "t1");
    chk("t1_start_count", 32'(starts - s0), 32'(nfr));
    chk("t1_ready0_pulses", 32'(ready_cnt[0] - r0), 32'd2);
    check_bytes("t1");
    check_pops("t1");

    // Contention: requesters 1 and 3, two bytes each
    exp_hdr(1); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_hdr(3); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_pop = '{1, 1, 3, 3};
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
    wait_idle(600, "t2");
    check_bytes("t2");
    check_pops("t2");

    // Fairness: everyone valid with 1-byte packets, requester 0 has two
    exp_hdr(0); exp_q.push_back(8'h01);
    exp_hdr(1); exp_q.push_back(8'h41);
    exp_hdr(2); exp_q.push_back(8'h42);
    exp_hdr(3); exp_q.push_back(8'h43);
    exp_hdr(0); exp_q.push_back(8'h02);
    exp_pop = '{0, 1, 2, 3, 0};
    push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
    push(1, 8'h41, 1'b1); push(2, 8'h42, 1'b1); push(3, 8'h43, 1'b1);
    wait_idle(1000, "t3");
    check_bytes("t3");
    check_pops("t3");

    // Gap timeout: requester 2 stalls after one non-last byte
    exp_hdr(2); exp_q.push_back(8'h2A);
    exp_hdr(3); exp_q.push_back(8'h3B);
    exp_pop = '{2, 3};
    push(2, 8'h2A, 1'b0);
    push(3, 8'h3B, 1'b1);
    n = 0;
    while (!bus.gap_abort && n < 300) begin @(negedge clk); n++; end
    chk("t4_abort_seen", 32'(n < 300), 32'd1);
    // Last tx_ready rise at edge T; FETCH entered at T+1; abort registered 16 clk later.
    chk("t4_abort_time", 32'($time - rise_t), 32'(17 * P + P / 2));
    chk("t4_busy_at_abort", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("t4_abort_one_cycle", 32'(bus.gap_abort), 32'd0);
    wait_idle(300, "t4");
    check_bytes("t4");
    check_pops("t4");

    // Reset while the UART frame is in flight
    exp_hdr(0); exp_q.push_back(8'h77);
    exp_hdr(0); exp_q.push_back(8'h78);
    exp_pop = '{0, 0};
    push(0, 8'h77, 1'b0);
    push(0, 8'h78, 1'b1);
    n = 0;
    while (!(bus.busy && !uart_rdy && !bus.start_tx && sent_q.size() == (HDR_ON ? 2 : 1))
           && n < 300) begin
      @(negedge clk); n++;
    end
    chk("t5_reach_shift", 32'(n < 300), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_start_tx_after_rst", 32'(bus.start_tx), 32'd0);
    chk("t5_busy_after_rst",     32'(bus.busy),     32'd0);
    chk("t5_uart_still_busy",    32'(uart_rdy),     32'd0);
    seen = 1'b0;
    n = 0;
    while (!uart_rdy && n < 50) begin
      if (bus.start_tx || bus.busy) seen = 1'b1;
      @(negedge clk); n++;
    end
    chk("t5_no_start_while_uart_busy", 32'(seen), 32'd0);
    wait_idle(300, "t5");
    check_bytes("t5");
    check_pops("t5");

    // Header build: requester 1 sends one byte
    r0 = ready_cnt[1];
    exp_hdr(1); exp_q.push_back(8'h10);
    exp_pop = '{1};
    push(1, 8'h10, 1'b1);
    wait_idle(300, "t6");
    chk("t6_ready1_pulses", 32'(ready_cnt[1] - r0), 32'd1);
    check_bytes("t6");
    check_pops("t6");

    chk("req_ready_onehot", 32'(multi_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet-level round-robin scheduler that shares the single UART transmitter among N_REQ byte-stream requesters, e.g. sample streamer, trigger status and command replies. It sits between the requesters and the UART `tx_data`/`start_tx`/`tx_ready` port. It owns the start handshake across the UART's slow baud-clock domain, and it sends each requester's packet contiguously, without interleaving.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GAP_TIMEOUT, 1024, clk cycles a granted requester may hold no byte before its packet is abandoned
- ID_BASE, 8'hA0, header byte base; header = ID_BASE + grant index (header build only)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i]
- req_data  in  8*N_REQ  byte per requester
- req_last  in  N_REQ  byte is the final byte of the packet
- req_ready  out  N_REQ  byte accepted this cycle; one-hot or zero
- tx_data  out  8  byte to UART; stable while start_tx=1 and until tx_ready returns high
- start_tx  out  1  start request to UART
- tx_ready  in  1  UART idle (low while a frame is in progress)
- grant_id  out  $clog2(N_REQ)  current owner; valid while busy=1
- busy  out  1  a packet is in progress
- gap_abort  out  1  one-cycle pulse when a packet is abandoned by timeout

## Operation
- States: IDLE, HDR (header build only), FETCH, START, SHIFT.
- IDLE:
  - Arbitrate only when tx_ready=1 and some req_valid=1.
  - Winner is the first valid index searching from rr_ptr+1 mod N_REQ upward.
  - On a win: grant_id <= winner, busy <= 1, go to HDR or FETCH.
- HDR: tx_data <= ID_BASE + grant_id, hdr_flag <= 1, go to START.
- FETCH:
  - req_ready[grant_id] = 1 combinationally when req_valid[grant_id]=1. The transfer happens on that edge: tx_data <= byte, last_flag <= req_last, gap counter cleared, go to START.
  - With no valid byte, the gap counter increments.
  - When the counter reaches GAP_TIMEOUT-1: pulse gap_abort, rr_ptr <= grant_id, go to IDLE.
- START:
  - start_tx=1 (registered), held until tx_ready is sampled 0.
  - On that sample, start_tx <= 0 and go to SHIFT.
  - The hold is required because the UART samples start_tx only on baud edges.
- SHIFT: wait for tx_ready=1, then:
  - If hdr_flag: clear it, go to FETCH.
  - Else if last_flag: rr_ptr <= grant_id, busy <= 0, go to IDLE.
  - Else go to FETCH.
- Other requesters' req_ready stays 0 for the whole packet; no preemption.
- Dropping req_valid mid-packet keeps the grant until GAP_TIMEOUT.
- A requester deasserting valid in IDLE before grant: no effect, arbitration is recomputed each cycle.
- gap counter width: $clog2(GAP_TIMEOUT)+1; saturates, never wraps.
- rr_ptr wraps N_REQ-1 -> 0.

## Timing
- Reset values:
  - start_tx=0, busy=0, gap_abort=0, req_ready=0, tx_data=8'h00, grant_id=0.
  - rr_ptr=N_REQ-1, so index 0 wins first; state=IDLE.
- Reset mid-frame: start_tx drops on the reset edge. The UART frame in flight finishes; the IDLE tx_ready=1 gate prevents a false handshake.
- IDLE -> FETCH: 1 cycle. FETCH -> START: 1 cycle once the byte is valid. start_tx rises the cycle after entering START.
- Per-byte overhead beyond the UART frame: 3 clk plus handshake latency of up to one baud period.
- rst takes priority over all transitions on the same edge.

## Configuration
- UART_TX_SCHED_HEADER_EN defined:
  - HDR state is present; every packet is preceded by one byte ID_BASE+grant_id.
  - hdr_flag suppresses req_ready for the header.
- Undefined: HDR state and hdr_flag are compiled out; IDLE goes straight to FETCH; the packet is sent raw.

## Structure
- Package uart_pkg:
  - state enum sched_state_t {IDLE, HDR, FETCH, START, SHIFT}.
  - Default localparams for N_REQ, GAP_TIMEOUT, ID_BASE.
- One sub-module: rr_arbiter (N_REQ request vector + rr_ptr in, one-hot grant + index out), purely combinational. The FSM, gap counter and handshake stay in uart_tx_sched.

## Test plan
- Single packet: req 0 sends 8'h55, 8'h3C (last) against a UART model that drops tx_ready 3 clk after start_tx.
  - tx_data sequence 55, 3C; one start_tx per byte; busy falls after the second tx_ready rise; rr_ptr=0.
- Contention: req 1 and req 3 both valid with 2-byte packets.
  - Req 1 is sent fully, then req 3; req_ready[3] stays 0 during the req 1 packet.
- Fairness: all four requesters continuously valid with 1-byte packets.
  - Grant order 0,1,2,3,0.
- Gap timeout with GAP_TIMEOUT=16: req 2 sends one non-last byte, then drops valid.
  - gap_abort pulses exactly 16 clk after FETCH entry; busy=0; req 3 is granted next.
- Reset mid-frame: assert rst while in SHIFT with tx_ready=0.
  - start_tx=0 next cycle; no new start_tx until tx_ready=1.
- Header build: req 1 sends 8'h10 (last) with UART_TX_SCHED_HEADER_EN defined.
  - tx_data sequence A1, 10; req_ready[1] pulses once.
